mantissa_normalize_round: RTL
=============================

MANTISSA_NORMALIZE_ROUND -- requirements
Module: mantissa_normalize_round

Interface
REQ-001 SHALL have parameter MANT_W, default 24: significand width including the hidden bit.
REQ-002 SHALL have parameter EXP_W, default 8: biased exponent width.
REQ-003 SHALL have port Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Clear_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: request to normalize and round one operand.
REQ-006 SHALL have port mant_in, input, MANT_W+1: raw adder sum; bit MANT_W is the carry-out, bit MANT_W-1 is the hidden-bit position.
REQ-007 SHALL have port exp_in, input, EXP_W: biased exponent of the aligned operands; legal range 1..254.
REQ-008 SHALL have ports guard_in, round_in and sticky_in, each input, 1: GRS bits from the alignment stage.
REQ-009 SHALL have port busy, output, 1: high from the start-accept edge until done rises.
REQ-010 SHALL have port done, output, 1: one-cycle pulse marking valid results.
REQ-011 SHALL have port mant_out, output, MANT_W-1: stored fraction with the hidden bit removed.
REQ-012 SHALL have port exp_out, output, EXP_W: result biased exponent.
REQ-013 SHALL have ports zero, overflow and denorm, each output, 1: result-class flags.

Function
REQ-014 SHALL implement FSM states IDLE, NORM, ROUND and DONE.
REQ-015 In IDLE with start=1, SHALL capture mant_in, exp_in and GRS into working registers, set busy, and go to NORM; start SHALL be ignored in any other state.
REQ-016 In NORM with carry=1, SHALL right-shift once (sticky |= round; round = guard; guard = mant[0]), increment exp, and go to ROUND.
REQ-017 In NORM with working mantissa and G/R all zero, SHALL set exp to 0 and zero=1, and go to ROUND.
REQ-018 In NORM with hidden bit set, SHALL go to ROUND.
REQ-019 In NORM with hidden bit clear and exp==1, SHALL set exp to 0 and denorm=1, and go to ROUND.
REQ-020 Otherwise in NORM, SHALL left-shift once (mant[0] = guard; guard = round; round = 0; sticky held), decrement exp, and stay in NORM.
REQ-021 In ROUND, SHALL apply round-to-nearest-even: increment when G & (R | S | mant[0]).
REQ-022 SHALL handle rounding carry-out: mantissa becomes 1.000..., exp += 1, and a denormal that rounds up to the hidden bit sets exp = 1 with denorm=0.
REQ-023 If exp reaches 255 (carry or rounding), SHALL force mant_out=0, exp_out=255 and overflow=1.
REQ-024 Results SHALL be registered on leaving ROUND; then DONE, with done=1 for exactly one cycle and busy=0, then back to IDLE.
REQ-025 Latency from the start-accept edge to done high SHALL be 3+k cycles, where k = left shifts (0..MANT_W-1); a carry takes 3 cycles.
REQ-026 Outputs SHALL hold their values until the next done; flags SHALL reflect only the latest result.

Reset
REQ-027 Clear_n=0 SHALL asynchronously force IDLE, busy=0, done=0, mant_out=0, exp_out=0, zero=0, overflow=0, denorm=0 and working registers to 0, including mid-operation; an in-flight operation is discarded without done.
REQ-028 The first start after Clear_n deasserts SHALL be accepted normally.

Structure
REQ-029 Shared header fp_adder_defs.vh SHALL hold MANT_W, EXP_W, EXP_MAX=255, and the FSM state encodings.
REQ-030 The shifter SHALL be one sub-module, normalize_shift_register: MANT_W+3 bit working register (carry, mantissa, G, R) plus sticky, with hold, load, left-1 and right-1 modes and an async active-low clear.
REQ-031 FSM, exponent counter and rounding incrementer SHALL live in the top module.

Verification
REQ-032 mant_in=25'h0800000, exp_in=127, GRS=000 -> done 3 cycles after start, mant_out=0, exp_out=127, all flags 0.
REQ-033 mant_in=25'h1000000, exp_in=127 -> exp_out=128, mant_out=0; the same input with exp_in=254 -> exp_out=255, mant_out=0, overflow=1.
REQ-034 mant_in=25'h0000001, exp_in=127, GRS=000 -> 23 shifts, done at cycle 26, exp_out=104, mant_out=0.
REQ-035 Rounding: mant_in=25'h0800001, GRS=100 -> mant_out=23'h000002; mant_in=25'h0800000, GRS=100 -> mant_out=0 (tie to even); mant_in=25'h0FFFFFF, GRS=110, exp_in=127 -> mant_out=0, exp_out=128.
REQ-036 mant_in=0, GRS=000 -> zero=1, exp_out=0, mant_out=0; mant_in=25'h0000100, exp_in=3 -> denorm=1, exp_out=0, mant_out=23'h000400.
REQ-037 Clear_n pulsed low during NORM of the 23-shift case -> outputs 0 immediately, no done, next start completes correctly; start pulsed while busy -> ignored.

Source files
------------

// File: rtl/mantissa_normalize_round_pkg.sv
// Shared definitions for the mantissa normalize/round block.
// Holds the default significand and exponent widths, the largest biased
// exponent, the FSM state encoding, the shifter mode encoding and the
// round-to-nearest-even decision helper.
package mantissa_normalize_round_pkg;

  localparam int MANT_W_DEF = 24;  // significand width including hidden bit
  localparam int EXP_W_DEF  = 8;   // biased exponent width
  localparam int EXP_MAX    = 255; // all-ones exponent at the default width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SH_HOLD  = 2'd0,
    SH_LOAD  = 2'd1,
    SH_LEFT  = 2'd2,
    SH_RIGHT = 2'd3
  } shift_mode_e;

  // Round to nearest, ties to even: bump when the guard bit is set and the
  // discarded part is above half, or exactly half with an odd LSB.
  function automatic logic rne_increment(input logic guard, input logic round,
                                         input logic sticky, input logic lsb);
    return guard & (round | sticky | lsb);
  endfunction

endpackage

// File: rtl/normalize_shift_register.sv
// Working register for normalization: {carry, mantissa[MANT_W-1:0], G, R}
// plus a separate sticky bit.
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - asynchronous active-low clear
//   mode_i     - SH_HOLD / SH_LOAD / SH_LEFT / SH_RIGHT
//   mant_i     - raw sum to load (bit MANT_W is the carry-out)
//   guard_i, round_i, sticky_i - GRS bits to load
//   vec_o      - {carry, mantissa, G, R}
//   sticky_o   - sticky bit
module normalize_shift_register
  import mantissa_normalize_round_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  shift_mode_e       mode_i,
  input  logic [MANT_W:0]   mant_i,
  input  logic              guard_i,
  input  logic              round_i,
  input  logic              sticky_i,
  output logic [MANT_W+2:0] vec_o,
  output logic              sticky_o
);

  logic [MANT_W+2:0] vec_q, vec_d;
  logic              sticky_q, sticky_d;

  always_comb begin
    vec_d    = vec_q;
    sticky_d = sticky_q;
    case (mode_i)
      SH_LOAD: begin
        vec_d    = {mant_i, guard_i, round_i};
        sticky_d = sticky_i;
      end
      // Left: mantissa LSB takes G, G takes R, R fills with 0; sticky held.
      SH_LEFT:  vec_d = {vec_q[MANT_W+1:0], 1'b0};
      // Right: the bit falling off R is folded into sticky.
      SH_RIGHT: begin
        vec_d    = {1'b0, vec_q[MANT_W+2:1]};
        sticky_d = sticky_q | vec_q[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vec_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      vec_q    <= vec_d;
      sticky_q <= sticky_d;
    end
  end

  assign vec_o    = vec_q;
  assign sticky_o = sticky_q;

endmodule

// File: rtl/mantissa_normalize_round.sv
// Normalizes the raw sum of a floating-point adder one bit per cycle and
// rounds it to nearest-even, producing a stored fraction, biased exponent
// and result-class flags.
// Ports:
//   Clk, Clear_n          - clock (rising edge), async active-low reset
//   start                 - request; sampled only while idle
//   mant_in               - raw sum, bit MANT_W = carry, bit MANT_W-1 = hidden
//   exp_in                - biased exponent (1..max-1)
//   guard_in/round_in/sticky_in - GRS from alignment
//   busy                  - operation in flight
//   done                  - one-cycle pulse, results valid
//   mant_out, exp_out     - fraction (hidden bit removed), biased exponent
//   zero, overflow, denorm - result-class flags
//   dbg_state             - current FSM state
//
// Handshake: a start seen while idle is accepted on that rising edge and
// busy rises with it; start at any other time is dropped. busy falls on
// the same edge that raises done, done lasts exactly one cycle, and a new
// start may be presented during that done cycle. Results stay stable
// until they are replaced by the next operation's results.
module mantissa_normalize_round
  import mantissa_normalize_round_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic              Clk,
  input  logic              Clear_n,
  input  logic              start,
  input  logic [MANT_W:0]   mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic              guard_in,
  input  logic              round_in,
  input  logic              sticky_in,
  output logic              busy,
  output logic              done,
  output logic [MANT_W-2:0] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              zero,
  output logic              overflow,
  output logic              denorm,
  output state_e            dbg_state
);

  // One extra exponent bit so a rounding carry out of the top exponent
  // cannot wrap back into range.
  localparam int XE_W = EXP_W + 1;
  localparam logic [XE_W-1:0] EXP_TOP = XE_W'((1 << EXP_W) - 1);

  state_e state_q, state_d;
  logic [XE_W-1:0] exp_q, exp_d;
  logic            wzero_q, wzero_d;   // working zero flag
  logic            wden_q, wden_d;     // working denormal flag
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [MANT_W-2:0] mant_out_q, mant_out_d;
  logic [EXP_W-1:0]  exp_out_q, exp_out_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              den_q, den_d;

  shift_mode_e       sh_mode;
  logic [MANT_W+2:0] vec;
  logic              sticky;

  normalize_shift_register #(
    .MANT_W (MANT_W)
  ) u_shift (
    .clk_i    (Clk),
    .rst_ni   (Clear_n),
    .mode_i   (sh_mode),
    .mant_i   (mant_in),
    .guard_i  (guard_in),
    .round_i  (round_in),
    .sticky_i (sticky_in),
    .vec_o    (vec),
    .sticky_o (sticky)
  );

  // Field views of the working vector.
  logic              w_carry;
  logic [MANT_W-1:0] w_mant;
  logic              w_guard;
  logic              w_round;

  assign w_carry = vec[MANT_W+2];
  assign w_mant  = vec[MANT_W+1:2];
  assign w_guard = vec[1];
  assign w_round = vec[0];

  // Rounding incrementer.
  logic              rnd_inc;
  logic [MANT_W:0]   rnd_sum;
  logic [XE_W-1:0]   rnd_exp;
  logic              rnd_den;
  logic              rnd_ovf;

  always_comb begin
    rnd_inc = rne_increment(w_guard, w_round, sticky, w_mant[0]);
    rnd_sum = {1'b0, w_mant} + {{MANT_W{1'b0}}, rnd_inc};
    rnd_exp = exp_q;
    rnd_den = wden_q;
    if (rnd_sum[MANT_W]) begin
      // 1.111..1 rounded up: the fraction bits of the sum are already all
      // zero, which is exactly 1.000..0 one binade higher.
      rnd_exp = exp_q + XE_W'(1);
    end else if (wden_q && rnd_sum[MANT_W-1]) begin
      // Largest denormal rounded into the smallest normal.
      rnd_exp = XE_W'(1);
      rnd_den = 1'b0;
    end
    rnd_ovf = (rnd_exp >= EXP_TOP);
  end

  // FSM next state, exponent counter and result capture.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    wzero_d    = wzero_q;
    wden_d     = wden_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mant_out_d = mant_out_q;
    exp_out_d  = exp_out_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    den_d      = den_q;
    sh_mode    = SH_HOLD;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sh_mode = SH_LOAD;
          exp_d   = {1'b0, exp_in};
          wzero_d = 1'b0;
          wden_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_NORM;
        end
      end

      ST_NORM: begin
        if (w_carry) begin
          sh_mode = SH_RIGHT;
          exp_d   = exp_q + XE_W'(1);
          state_d = ST_ROUND;
        end else if (w_mant == '0 && !w_guard && !w_round) begin
          exp_d   = '0;
          wzero_d = 1'b1;
          state_d = ST_ROUND;
        end else if (w_mant[MANT_W-1]) begin
          state_d = ST_ROUND;
        end else if (exp_q <= XE_W'(1)) begin
          // Cannot shift further without leaving the exponent range.
          exp_d   = '0;
          wden_d  = 1'b1;
          state_d = ST_ROUND;
        end else begin
          sh_mode = SH_LEFT;
          exp_d   = exp_q - XE_W'(1);
        end
      end

      ST_ROUND: begin
        zero_d  = wzero_q;
        ovf_d   = rnd_ovf;
        if (rnd_ovf) begin
          mant_out_d = '0;
          exp_out_d  = EXP_TOP[EXP_W-1:0];
          den_d      = 1'b0;
        end else begin
          mant_out_d = rnd_sum[MANT_W-2:0];
          exp_out_d  = rnd_exp[EXP_W-1:0];
          den_d      = rnd_den;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q    <= ST_IDLE;
      exp_q      <= '0;
      wzero_q    <= 1'b0;
      wden_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mant_out_q <= '0;
      exp_out_q  <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      den_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      wzero_q    <= wzero_d;
      wden_q     <= wden_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mant_out_q <= mant_out_d;
      exp_out_q  <= exp_out_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      den_q      <= den_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mant_out  = mant_out_q;
  assign exp_out   = exp_out_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign denorm    = den_q;
  assign dbg_state = state_q;

endmodule
